// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle LEGv8 control path.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    IC_ILLEGAL,
    IC_ADDI,
    IC_ADDS,
    IC_SUBS,
    IC_AND,
    IC_EOR,
    IC_LDUR,
    IC_STUR,
    IC_B,
    IC_BLT,
    IC_CBZ
  } inst_class_t;

  // Opcode patterns on IR[31:21]; '?' bits belong to immediates.
  localparam logic [10:0] OP_ADDI  = 11'b1001000100?;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_EOR   = 11'b11001010000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_B     = 11'b000101?????;
  localparam logic [10:0] OP_BCOND = 11'b01010100???;
  localparam logic [10:0] OP_CBZ   = 11'b10110100???;

  localparam logic [3:0]  COND_LT  = 4'b1011;

  localparam logic [2:0]  ALU_PASSB = 3'b000;
  localparam logic [2:0]  ALU_ADD   = 3'b010;
  localparam logic [2:0]  ALU_SUB   = 3'b011;
  localparam logic [2:0]  ALU_AND   = 3'b100;
  localparam logic [2:0]  ALU_XOR   = 3'b110;

  localparam logic [1:0]  PC_SEQ    = 2'b00;
  localparam logic [1:0]  PC_BR26   = 2'b01;
  localparam logic [1:0]  PC_BR19   = 2'b10;

  localparam logic [1:0]  SRC_REG    = 2'b00;
  localparam logic [1:0]  SRC_IMM12  = 2'b01;
  localparam logic [1:0]  SRC_DADDR9 = 2'b10;

  function automatic logic sets_flags(input inst_class_t c);
    return (c == IC_ADDS) || (c == IC_SUBS);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_inst_decoder.sv
// Combinational instruction classifier and datapath-field decoder.
module inst_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0]  ir,
  output inst_class_t  cls,
  output logic         illegal,
  output logic [2:0]   alu_op,
  output logic [1:0]   alu_src,
  output logic         reg2_sel
);

  // Register and immediate fields are consumed by the datapath, not here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^ir[20:4];

  // Classify the opcode field; only the LT condition is accepted for B.cond.
  always_comb begin
    cls = IC_ILLEGAL;
    casez (ir[31:21])
      OP_ADDI:  cls = IC_ADDI;
      OP_ADDS:  cls = IC_ADDS;
      OP_SUBS:  cls = IC_SUBS;
      OP_AND:   cls = IC_AND;
      OP_EOR:   cls = IC_EOR;
      OP_LDUR:  cls = IC_LDUR;
      OP_STUR:  cls = IC_STUR;
      OP_B:     cls = IC_B;
      OP_BCOND: cls = (ir[3:0] == COND_LT) ? IC_BLT : IC_ILLEGAL;
      OP_CBZ:   cls = IC_CBZ;
      default:  cls = IC_ILLEGAL;
    endcase
  end

  assign illegal = (cls == IC_ILLEGAL);

  // Datapath selects per class; STUR and CBZ both need Rt on read port 2.
  always_comb begin
    alu_op   = ALU_PASSB;
    alu_src  = SRC_REG;
    reg2_sel = 1'b0;
    case (cls)
      IC_ADDI: begin
        alu_op  = ALU_ADD;
        alu_src = SRC_IMM12;
      end
      IC_ADDS: alu_op = ALU_ADD;
      IC_SUBS: alu_op = ALU_SUB;
      IC_AND:  alu_op = ALU_AND;
      IC_EOR:  alu_op = ALU_XOR;
      IC_LDUR: begin
        alu_op  = ALU_ADD;
        alu_src = SRC_DADDR9;
      end
      IC_STUR: begin
        alu_op   = ALU_ADD;
        alu_src  = SRC_DADDR9;
        reg2_sel = 1'b1;
      end
      IC_CBZ: begin
        alu_op   = ALU_PASSB;
        reg2_sel = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM with data-memory handshake and trap state.
// Optional performance counters are enabled by defining CTRL_PERF_CNT_EN.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       instruction,
  input  logic              alu_zero,
  input  logic              flag_n,
  input  logic              flag_v,
  input  logic              mem_ack,
  output logic              pc_we,
  output logic [1:0]        pc_src,
  output logic              ir_we,
  output logic              reg_we,
  output logic              reg2_sel,
  output logic [1:0]        alu_src,
  output logic [2:0]        ALUOp,
  output logic              flag_we,
  output logic              mem_req,
  output logic              mem_wr,
  output logic              mem_to_reg,
  output logic              retire,
  output logic              trap
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instr_cnt
`endif
);

  localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t       state, next_state;
  logic [31:0]  ir;
  logic [TW-1:0] wait_cnt;
  logic         timeout_hit;

  inst_class_t  cls;
  logic         illegal;
  logic [2:0]   dec_alu_op;
  logic [1:0]   dec_alu_src;
  logic         dec_reg2_sel;

  inst_decoder u_dec (
    .ir       (ir),
    .cls      (cls),
    .illegal  (illegal),
    .alu_op   (dec_alu_op),
    .alu_src  (dec_alu_src),
    .reg2_sel (dec_reg2_sel)
  );

  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == TW'(MEM_TIMEOUT - 1));

  // State register and instruction latch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == S_FETCH) ir <= instruction;
    end
  end

  // Memory wait counter: counts only while staying in MEM, clears otherwise.
  always_ff @(posedge clk) begin
    if (!reset_n) wait_cnt <= '0;
    else if (state == S_MEM && next_state == S_MEM) wait_cnt <= wait_cnt + 1'b1;
    else wait_cnt <= '0;
  end

  // Next-state and per-state datapath controls; everything forced low in reset.
  always_comb begin
    next_state = state;
    pc_we      = 1'b0;
    pc_src     = PC_SEQ;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    reg2_sel   = 1'b0;
    alu_src    = SRC_REG;
    ALUOp      = ALU_PASSB;
    flag_we    = 1'b0;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    trap       = 1'b0;
    if (reset_n) begin
      if (state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
        ALUOp    = dec_alu_op;
        alu_src  = dec_alu_src;
        reg2_sel = dec_reg2_sel;
      end
      case (state)
        S_FETCH: begin
          ir_we      = 1'b1;
          next_state = S_DECODE;
        end
        S_DECODE: next_state = illegal ? S_TRAP : S_EXEC;
        S_EXEC: begin
          case (cls)
            IC_ADDI, IC_ADDS, IC_SUBS, IC_AND, IC_EOR: begin
              flag_we    = sets_flags(cls);
              next_state = S_WB;
            end
            IC_LDUR, IC_STUR: next_state = S_MEM;
            IC_B: begin
              pc_we      = 1'b1;
              pc_src     = PC_BR26;
              retire     = 1'b1;
              next_state = S_FETCH;
            end
            IC_CBZ: begin
              pc_we      = 1'b1;
              pc_src     = alu_zero ? PC_BR19 : PC_SEQ;
              retire     = 1'b1;
              next_state = S_FETCH;
            end
            IC_BLT: begin
              pc_we      = 1'b1;
              pc_src     = (flag_n != flag_v) ? PC_BR19 : PC_SEQ;
              retire     = 1'b1;
              next_state = S_FETCH;
            end
            default: next_state = S_TRAP;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_wr  = (cls == IC_STUR);
          if (mem_ack) begin
            if (cls == IC_STUR) begin
              pc_we      = 1'b1;
              retire     = 1'b1;
              next_state = S_FETCH;
            end else begin
              next_state = S_WB;
            end
          end else if (timeout_hit) begin
            next_state = S_TRAP;
          end
        end
        S_WB: begin
          reg_we     = 1'b1;
          mem_to_reg = (cls == IC_LDUR);
          pc_we      = 1'b1;
          retire     = 1'b1;
          next_state = S_FETCH;
        end
        S_TRAP: trap = 1'b1;
        default: next_state = S_FETCH;
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  // Cycle and retired-instruction counters; cycles stop accruing in TRAP.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != S_TRAP) cycle_cnt <= cycle_cnt + 1'b1;
      if (retire) instr_cnt <= instr_cnt + 1'b1;
    end
  end
`endif

endmodule
